// File: rtl/img_proc_pkg.sv
// -----------------------------------------------------------------------------
// img_proc_pkg
//   Shared definitions for the image-processing line buffer controllers.
//   Contents:
//     line_pop_state_t : state encoding of the line_pop_ctrl read-side FSM
//     ring_inc()       : increment of a ring index with wrap at an arbitrary
//                        (not necessarily power-of-two) ring size
// -----------------------------------------------------------------------------
package img_proc_pkg;

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    POP    = 3'd1,
    READ   = 3'd2,
    FLUSH  = 3'd3,
    REFILL = 3'd4,
    DONE   = 3'd5
  } line_pop_state_t;

  // Next index in a ring of 'size' entries; wraps from size-1 back to 0.
  function automatic int ring_inc(input int idx, input int size);
    return (idx == size - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/line_pop_ctrl.sv
// -----------------------------------------------------------------------------
// line_pop_ctrl
//   Read-side controller for a ring of LINES_AMOUNT line buffers forming a
//   vertical pixel window. Waits until every buffer holds a line, pops them all
//   together, waits for the last pixel of the window line, then flushes only the
//   oldest buffer so it can take the next input line. Repeats until all
//   FRAME_RES_Y - LINES_AMOUNT + 1 windows of the frame are done.
//
//   Ports:
//     clk_i         clock
//     rst_i         asynchronous active-high reset
//     sof_i         start of frame on the input stream (restarts the frame)
//     empty_i       per-buffer empty flag
//     unread_i      per-buffer "holds an unread line" flag
//     rd_last_i     last pixel of a window line accepted downstream
//     pop_line_o    one-cycle pop pulse per buffer
//     flush_line_o  one-cycle flush pulse per buffer
//     oldest_o      ring index of the oldest line (window row reordering)
//     win_cnt_o     windows completed in the current frame (saturating)
//     busy_o        high while in POP or READ
// -----------------------------------------------------------------------------
module line_pop_ctrl
  import img_proc_pkg::*;
#(
  parameter int LINES_AMOUNT = 3,
  parameter int FRAME_RES_Y  = 1080,
  parameter int CNT_WIDTH    = $clog2(FRAME_RES_Y + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            sof_i,
  input  logic [LINES_AMOUNT-1:0]         empty_i,
  input  logic [LINES_AMOUNT-1:0]         unread_i,
  input  logic                            rd_last_i,
  output logic [LINES_AMOUNT-1:0]         pop_line_o,
  output logic [LINES_AMOUNT-1:0]         flush_line_o,
  output logic [$clog2(LINES_AMOUNT)-1:0] oldest_o,
  output logic [CNT_WIDTH-1:0]            win_cnt_o,
  output logic                            busy_o
);

  localparam int IDX_W = $clog2(LINES_AMOUNT);
  localparam logic [CNT_WIDTH-1:0] WIN_TOTAL = CNT_WIDTH'(FRAME_RES_Y - LINES_AMOUNT + 1);

  line_pop_state_t           state, state_next;
  logic [LINES_AMOUNT-1:0]   pop_next, flush_next;
  logic [IDX_W-1:0]          oldest_next;
  logic [IDX_W-1:0]          flushed_idx, flushed_next;
  logic [CNT_WIDTH-1:0]      win_next;

  // Next-state and next-output logic. Pulses are decided on the edge that
  // enters POP/FLUSH so that they are visible exactly while the FSM sits in
  // that state. The ring pointer and window counter advance together with the
  // flush decision. sof_i overrides everything, so a pop or flush decided in
  // the same cycle is dropped; the buffers clear themselves on start of frame.
  always_comb begin
    state_next   = state;
    pop_next     = '0;
    flush_next   = '0;
    oldest_next  = oldest_o;
    flushed_next = flushed_idx;
    win_next     = win_cnt_o;
    if (sof_i) begin
      state_next  = FILL;
      oldest_next = '0;
      win_next    = '0;
    end else begin
      case (state)
        FILL: begin
          if ((&unread_i) && !(|empty_i)) begin
            state_next = POP;
            pop_next   = '1;
          end
        end
        POP: begin
          state_next = READ;
        end
        READ: begin
          // An empty buffer here is a protocol error and is deliberately ignored.
          if (rd_last_i) begin
            state_next   = FLUSH;
            flush_next   = LINES_AMOUNT'(1) << oldest_o;
            flushed_next = oldest_o;
            oldest_next  = IDX_W'(ring_inc(int'(oldest_o), LINES_AMOUNT));
            if (win_cnt_o != WIN_TOTAL) begin
              win_next = win_cnt_o + CNT_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          // Counter was already advanced on entry to FLUSH.
          state_next = (win_cnt_o == WIN_TOTAL) ? DONE : REFILL;
        end
        REFILL: begin
          if (unread_i[flushed_idx] && !empty_i[flushed_idx]) begin
            state_next = POP;
            pop_next   = '1;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end
  end

  // State, ring pointer, counter and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= FILL;
      pop_line_o   <= '0;
      flush_line_o <= '0;
      oldest_o     <= '0;
      flushed_idx  <= '0;
      win_cnt_o    <= '0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_next;
      pop_line_o   <= pop_next;
      flush_line_o <= flush_next;
      oldest_o     <= oldest_next;
      flushed_idx  <= flushed_next;
      win_cnt_o    <= win_next;
      busy_o       <= (state_next == POP) || (state_next == READ);
    end
  end

endmodule

// File: tb/tb_line_pop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_pop_ctrl
//   Directed self-checking bench for line_pop_ctrl with LINES_AMOUNT=3 and
//   FRAME_RES_Y=5 (three windows per frame).
// -----------------------------------------------------------------------------
module tb_line_pop_ctrl;

  localparam int LINES = 3;
  localparam int RES_Y = 5;
  localparam int CNT_W = $clog2(RES_Y + 1);

  logic             clock;
  logic             reset;
  logic             sof;
  logic [LINES-1:0] empty;
  logic [LINES-1:0] unread;
  logic             rdLast;
  logic [LINES-1:0] popLine;
  logic [LINES-1:0] flushLine;
  logic [1:0]       oldest;
  logic [CNT_W-1:0] winCnt;
  logic             busy;

  int assertCount = 0;
  int failCount   = 0;

  line_pop_ctrl #(
    .LINES_AMOUNT(LINES),
    .FRAME_RES_Y (RES_Y)
  ) dut (
    .clk_i       (clock),
    .rst_i       (reset),
    .sof_i       (sof),
    .empty_i     (empty),
    .unread_i    (unread),
    .rd_last_i   (rdLast),
    .pop_line_o  (popLine),
    .flush_line_o(flushLine),
    .oldest_o    (oldest),
    .win_cnt_o   (winCnt),
    .busy_o      (busy)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive all controller inputs at once.
  task automatic applyStimulus(input logic sofV, input logic [LINES-1:0] unreadV,
                               input logic [LINES-1:0] emptyV, input logic rdLastV);
    sof    = sofV;
    unread = unreadV;
    empty  = emptyV;
    rdLast = rdLastV;
  endtask

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stimulus sequence with hand-computed expectations.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("reset_pop",    32'(popLine),   32'h0);
    checkOutput("reset_flush",  32'(flushLine), 32'h0);
    checkOutput("reset_oldest", 32'(oldest),    32'h0);
    checkOutput("reset_win",    32'(winCnt),    32'h0);
    checkOutput("reset_busy",   32'(busy),      32'h0);
    reset = 1'b0;

    // First window: all buffers full.
    applyStimulus(1'b0, 3'b111, 3'b000, 1'b0);
    tick();
    checkOutput("w1_pop",  32'(popLine), 32'h7);
    checkOutput("w1_busy", 32'(busy),    32'h1);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("w1_pop_one_cycle", 32'(popLine), 32'h0);
    checkOutput("w1_read_busy",     32'(busy),    32'h1);
    tick();
    checkOutput("w1_read_no_flush", 32'(flushLine), 32'h0);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("w1_flush",  32'(flushLine), 32'h1);
    checkOutput("w1_oldest", 32'(oldest),    32'h1);
    checkOutput("w1_win",    32'(winCnt),    32'h1);
    checkOutput("w1_busy_after", 32'(busy),  32'h0);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("w1_flush_one_cycle", 32'(flushLine), 32'h0);

    // Refill of buffer 0, second window.
    tick();
    checkOutput("w2_no_pop_before_refill", 32'(popLine), 32'h0);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0);
    tick();
    checkOutput("w2_pop", 32'(popLine), 32'h7);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("w2_flush",  32'(flushLine), 32'h2);
    checkOutput("w2_oldest", 32'(oldest),    32'h2);
    checkOutput("w2_win",    32'(winCnt),    32'h2);

    // Third window, refill of buffer 1 (buffer 0 readiness must not matter).
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("w3_wrong_buf_no_pop", 32'(popLine), 32'h0);
    applyStimulus(1'b0, 3'b010, 3'b000, 1'b0);
    tick();
    checkOutput("w3_pop", 32'(popLine), 32'h7);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("w3_flush",  32'(flushLine), 32'h4);
    checkOutput("w3_oldest_wrap", 32'(oldest), 32'h0);
    checkOutput("w3_win",    32'(winCnt),    32'h3);

    // DONE: nothing happens until start of frame.
    applyStimulus(1'b0, 3'b111, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("done_no_pop",   32'(popLine),   32'h0);
      checkOutput("done_no_flush", 32'(flushLine), 32'h0);
      checkOutput("done_win_sat",  32'(winCnt),    32'h3);
    end

    // Start of frame restarts; pop follows one cycle later.
    applyStimulus(1'b1, 3'b111, 3'b000, 1'b0);
    tick();
    checkOutput("sof_win",    32'(winCnt),  32'h0);
    checkOutput("sof_oldest", 32'(oldest),  32'h0);
    checkOutput("sof_no_pop", 32'(popLine), 32'h0);
    applyStimulus(1'b0, 3'b111, 3'b000, 1'b0);
    tick();
    checkOutput("sof_fill_pop", 32'(popLine), 32'h7);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();

    // sof colliding with rd_last in READ: no flush.
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("sofread_no_flush", 32'(flushLine), 32'h0);
    checkOutput("sofread_oldest",   32'(oldest),    32'h0);
    checkOutput("sofread_win",      32'(winCnt),    32'h0);
    checkOutput("sofread_busy",     32'(busy),      32'h0);

    // FILL blocked by an empty buffer; rd_last ignored outside READ.
    applyStimulus(1'b0, 3'b111, 3'b010, 1'b0);
    tick();
    tick();
    checkOutput("empty_no_pop", 32'(popLine), 32'h0);
    applyStimulus(1'b0, 3'b111, 3'b010, 1'b1);
    tick();
    checkOutput("fill_rdlast_no_flush", 32'(flushLine), 32'h0);
    checkOutput("fill_rdlast_win",      32'(winCnt),    32'h0);
    applyStimulus(1'b0, 3'b111, 3'b000, 1'b0);
    tick();
    checkOutput("empty_cleared_pop", 32'(popLine), 32'h7);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("f2_flush", 32'(flushLine), 32'h1);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("f2_refill_pop", 32'(popLine), 32'h7);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("f2_read_busy", 32'(busy), 32'h1);

    // Asynchronous reset mid-READ.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_busy",   32'(busy),   32'h0);
    checkOutput("async_oldest", 32'(oldest), 32'h0);
    checkOutput("async_win",    32'(winCnt), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 3'b111, 3'b000, 1'b1);
    tick();
    checkOutput("post_reset_fill_pop",   32'(popLine),   32'h7);
    checkOutput("post_reset_no_flush",   32'(flushLine), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
